// File: rtl/adder_datapath_control.sv
// adder_datapath_control
//   Two-operand 16-bit adder split into a control FSM and a datapath.
//   Operand words arrive one at a time on din, qualified by irdy. Each
//   consecutive pair (A then B) is summed mod 2^16. The sum appears on
//   dout together with a single-cycle ordy strobe.
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous active-high reset
//   din    in  16   operand word, sampled when irdy=1 in a load state
//   irdy   in   1   din valid this cycle
//   dout   out 16   registered sum, holds until the next result
//   ordy   out  1   one-cycle strobe marking a new result on dout

module adder_datapath_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        irdy,
  output logic [15:0] dout,
  output logic        ordy
);

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StAdd,
    StOut
  } state_e;

  state_e state_q;

  // Control -> datapath strobes
  logic load_a;
  logic load_b;
  logic do_add;

  // Datapath registers
  logic [15:0] reg_a;
  logic [15:0] reg_b;
  logic [15:0] sum_reg;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLoadA;
    end else begin
      unique case (state_q)
        StLoadA: if (irdy) state_q <= StLoadB;
        StLoadB: if (irdy) state_q <= StAdd;
        StAdd:   state_q <= StOut;
        StOut:   state_q <= StLoadA;
        default: state_q <= StLoadA;
      endcase
    end
  end

  // Strobes decode from registered state only; irdy is ignored in StAdd/StOut
  // so words presented there are simply dropped.
  always_comb begin
    load_a = 1'b0;
    load_b = 1'b0;
    do_add = 1'b0;
    unique case (state_q)
      StLoadA: load_a = irdy;
      StLoadB: load_b = irdy;
      StAdd:   do_add = 1'b1;
      StOut:   ;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_a   <= 16'h0000;
      reg_b   <= 16'h0000;
      sum_reg <= 16'h0000;
    end else begin
      if (load_a) reg_a <= din;
      if (load_b) reg_b <= din;
      // Carry out of bit 15 is intentionally discarded.
      if (do_add) sum_reg <= reg_a + reg_b;
    end
  end

  assign dout = sum_reg;
  // Pure state decode: glitch-free and cleared asynchronously with the state.
  assign ordy = (state_q == StOut);

endmodule

// File: tb/tb_adder_datapath_control.sv
module tb_adder_datapath_control;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        irdy;
  logic [15:0] dout;
  logic        ordy;

  int errors = 0;
  int checks = 0;

  // Behavioural model: words are paired in arrival order; after a pair is
  // complete the block is deaf for two edges, and the sum shows up with
  // ordy for the cycle following the first of those edges.
  logic        m_have_a;
  logic [15:0] m_a;
  logic [15:0] m_b;
  int          m_deaf;
  logic [15:0] m_sum;
  logic        m_ordy;

  adder_datapath_control dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .irdy (irdy),
    .dout (dout),
    .ordy (ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic model_clear();
    m_have_a = 1'b0;
    m_a      = 16'h0;
    m_b      = 16'h0;
    m_deaf   = 0;
    m_sum    = 16'h0;
    m_ordy   = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, pass one rising edge, advance the
  // model, return at the next falling edge.
  task automatic step(input logic r, input logic i, input logic [15:0] d);
    reset = r;
    irdy  = i;
    din   = d;
    if (r) model_clear();
    @(posedge clk);
    if (!r) begin
      m_ordy = 1'b0;
      if (m_deaf == 2) begin
        m_sum  = 16'(m_a + m_b);
        m_ordy = 1'b1;
        m_deaf = 1;
      end else if (m_deaf == 1) begin
        m_deaf = 0;
      end else if (i) begin
        if (!m_have_a) begin
          m_a      = d;
          m_have_a = 1'b1;
        end else begin
          m_b      = d;
          m_have_a = 1'b0;
          m_deaf   = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dout !== 16'h0 || ordy !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: dout=%h ordy=%b, required dout=0000 ordy=0", dout, ordy);
    end
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'(k & 1), 16'($urandom));
      checks++;
      if (dout !== 16'h0 || ordy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: dout=%h ordy=%b, required dout=0000 ordy=0", k, dout, ordy);
      end
    end
  endtask

  task automatic test_basic_pair();
    step(1'b0, 1'b1, 16'h0001);
    step(1'b0, 1'b0, 16'h1234);
    step(1'b0, 1'b0, 16'h4321);
    step(1'b0, 1'b1, 16'h0002);
    checks++;
    if (ordy !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: ordy=%b right after B capture, required 0", ordy);
    end
    step(1'b0, 1'b0, 16'h0000);
    checks++;
    if (ordy !== 1'b1 || dout !== 16'h0003) begin
      errors++;
      $display("FAIL basic_result: dout=%h ordy=%b, required dout=0003 ordy=1", dout, ordy);
    end
    step(1'b0, 1'b0, 16'h0000);
    checks++;
    if (ordy !== 1'b0 || dout !== 16'h0003) begin
      errors++;
      $display("FAIL basic_after: dout=%h ordy=%b, required dout=0003 ordy=0", dout, ordy);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] av [2];
    logic [15:0] bv [2];
    logic [15:0] ev [2];
    av[0] = 16'hFFFF; bv[0] = 16'h0002; ev[0] = 16'h0001;
    av[1] = 16'h8000; bv[1] = 16'h8000; ev[1] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      step(1'b0, 1'b1, av[p]);
      step(1'b0, 1'b1, bv[p]);
      step(1'b0, 1'b1, 16'h5555);
      checks++;
      if (ordy !== 1'b1 || dout !== ev[p] || dout !== m_sum) begin
        errors++;
        $display("FAIL overflow[%0d]: dout=%h ordy=%b, required dout=%h ordy=1",
                 p, dout, ordy, ev[p]);
      end
      step(1'b0, 1'b1, 16'hAAAA);
    end
  endtask

  task automatic test_streaming();
    int pulse_at [$];
    logic [15:0] pulse_val [$];
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 16'(k));
      if (ordy === 1'b1) begin
        pulse_at.push_back(k);
        pulse_val.push_back(dout);
      end
      checks++;
      if (dout !== m_sum || ordy !== m_ordy) begin
        errors++;
        $display("FAIL stream_cycle[%0d]: dout=%h ordy=%b, required dout=%h ordy=%b",
                 k, dout, ordy, m_sum, m_ordy);
      end
    end
    checks++;
    if (pulse_at.size() != 2) begin
      errors++;
      $display("FAIL stream_pulses: got %0d ordy pulses, required 2", pulse_at.size());
    end else begin
      checks++;
      if (pulse_val[0] !== 16'h0003 || pulse_val[1] !== 16'h000B) begin
        errors++;
        $display("FAIL stream_values: got %h,%h, required 0003,000b", pulse_val[0], pulse_val[1]);
      end
      checks++;
      if (pulse_at[1] - pulse_at[0] != 4) begin
        errors++;
        $display("FAIL stream_spacing: pulses %0d cycles apart, required 4",
                 pulse_at[1] - pulse_at[0]);
      end
    end
  endtask

  task automatic test_mid_pair_reset();
    step(1'b0, 1'b1, 16'h0010);
    reset = 1'b1;
    #1;
    checks++;
    if (dout !== 16'h0 || ordy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: dout=%h ordy=%b, required dout=0000 ordy=0", dout, ordy);
    end
    step(1'b1, 1'b1, 16'h7777);
    step(1'b0, 1'b1, 16'h0004);
    step(1'b0, 1'b1, 16'h0005);
    step(1'b0, 1'b0, 16'h0000);
    checks++;
    if (dout !== 16'h0009 || ordy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_result: dout=%h ordy=%b, required dout=0009 ordy=1", dout, ordy);
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 16'($urandom));
      checks++;
      if (dout !== 16'h0009 || ordy !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: dout=%h ordy=%b, required dout=0009 ordy=0", k, dout, ordy);
      end
    end
  endtask

  task automatic test_random();
    logic r;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 29) == 0);
      step(r, 1'($urandom_range(0, 2) != 0), 16'($urandom));
      checks++;
      if (dout !== m_sum || ordy !== m_ordy) begin
        errors++;
        $display("FAIL random[%0d]: dout=%h ordy=%b, required dout=%h ordy=%b",
                 k, dout, ordy, m_sum, m_ordy);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    irdy  = 1'b0;
    din   = 16'h0;
    model_clear();
    test_reset();
    test_basic_pair();
    test_overflow();
    test_streaming();
    test_mid_pair_reset();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
